tap_ir_controller: RTL
======================

TAP_IR_CONTROLLER -- requirements
Module: tap_ir_controller

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 4: instruction register width (>=2).
REQ-002 SHALL have parameter IDCODE_OP, default 4'b0001: instruction loaded on reset and in Test-Logic-Reset.
REQ-003 SHALL have parameter IR_CAPTURE, default 4'b0001: value captured in Capture-IR (LSBs fixed 01).
REQ-004 SHALL have port TCK, input, 1: the single clock; all state changes on rising edge.
REQ-005 SHALL have port TRST, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port TMS, input, 1: test mode select, sampled on TCK rising edge.
REQ-007 SHALL have port TDI, input, 1: serial data in.
REQ-008 SHALL have port tap_state, output, 4: current TAP state encoding (REQ-011).
REQ-009 SHALL have ports ir_tdo, output, 1: IR serial out; and tdo_en, output, 1: TDO drive enable.
REQ-010 SHALL have outputs dr_capture, dr_shift, dr_update, ir_shift (1 bit each, per-state strobes) and parallel_out (IR_WIDTH, current instruction, consumed by instruction_decoder).

Function
REQ-011 SHALL encode states: TLR=0, RTI=1, SEL_DR=2, CAP_DR=3, SHIFT_DR=4, EXIT1_DR=5, PAUSE_DR=6, EXIT2_DR=7, UPD_DR=8, SEL_IR=9, CAP_IR=10, SHIFT_IR=11, EXIT1_IR=12, PAUSE_IR=13, EXIT2_IR=14, UPD_IR=15.
REQ-012 SHALL transition on each edge as IEEE 1149.1 (next for TMS=0 / TMS=1): TLR RTI/TLR; RTI RTI/SEL_DR; SEL_DR CAP_DR/SEL_IR; SEL_IR CAP_IR/TLR; CAP_x SHIFT_x/EXIT1_x; SHIFT_x SHIFT_x/EXIT1_x; EXIT1_x PAUSE_x/UPD_x; PAUSE_x PAUSE_x/EXIT2_x; EXIT2_x SHIFT_x/UPD_x; UPD_x RTI/SEL_DR.
REQ-013 SHALL reach TLR within 5 edges of TMS=1 from any state.
REQ-014 SHALL drive dr_capture, dr_shift, dr_update, ir_shift high combinationally while tap_state is CAP_DR, SHIFT_DR, UPD_DR, SHIFT_IR respectively; otherwise low.
REQ-015 SHALL assert tdo_en combinationally exactly while tap_state is SHIFT_DR or SHIFT_IR.
REQ-016 SHALL hold an IR_WIDTH shift register ir_sr; on an edge in CAP_IR: ir_sr <= IR_CAPTURE.
REQ-017 SHALL on an edge in SHIFT_IR shift right: ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]}; ir_sr unchanged in all other states.
REQ-018 SHALL drive ir_tdo = ir_sr[0] combinationally at all times.
REQ-019 SHALL on an edge in UPD_IR load parallel_out <= ir_sr; the new instruction is visible the cycle the TAP is in RTI or SEL_DR (1-edge latency).
REQ-020 SHALL on every edge in TLR load parallel_out <= IDCODE_OP; otherwise parallel_out holds, including through PAUSE_IR and DR scans.
REQ-021 SHALL leave parallel_out unchanged when an IR scan exits without passing UPD_IR (impossible per REQ-012; aborted scans still reach UPD_IR, which commits ir_sr as-is).
REQ-022 SHALL when TRST and any TMS/TDI coincide give TRST priority: no shift, capture or update that edge.

Reset
REQ-023 SHALL on an edge with TRST=1 set tap_state=TLR, parallel_out=IDCODE_OP, ir_sr=IR_CAPTURE; all strobes and tdo_en therefore 0, ir_tdo=IR_CAPTURE[0]=1.
REQ-024 SHALL honour TRST mid-scan (e.g. in SHIFT_IR): partial ir_sr contents discarded, parallel_out=IDCODE_OP the next cycle.

Verification
REQ-025 SHALL cover: TRST=1 one edge from SHIFT_DR -> tap_state=0, parallel_out=4'b0001, tdo_en=0.
REQ-026 SHALL cover: from RTI, TMS=1,1,1,1,1 -> tap_state=0 after the fifth edge; also verified starting in each of the 16 states.
REQ-027 SHALL cover: IR load of 4'b1111 (TMS 1,1,0,0 then TDI=1 x4 with TMS=0,0,0,1, then TMS=1,0) -> ir_tdo emits 1,0,0,0 during shift, parallel_out=4'b1111 in RTI.
REQ-028 SHALL cover: IR scan with pause (SHIFT_IR 2 bits, EXIT1, PAUSE 3 edges, EXIT2, 2 more bits) -> ir_sr contains all 4 TDI bits in order, parallel_out updated only at UPD_IR.
REQ-029 SHALL cover: DR path walk RTI->SEL_DR->CAP_DR->SHIFT_DR x3->EXIT1_DR->UPD_DR -> dr_capture 1 cycle, dr_shift 3 cycles, dr_update 1 cycle, parallel_out unchanged.
REQ-030 SHALL cover: after loading 4'b0101, enter TLR via TMS=1 -> parallel_out returns to 4'b0001 on first TLR edge.

Source files
------------

// File: rtl/tap_ir_controller.sv
// tap_ir_controller: IEEE 1149.1 TAP state machine with instruction register
module tap_ir_controller #(
  parameter int                  IR_WIDTH   = 4,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP  = 4'b0001,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE = 4'b0001
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic [3:0]          tap_state,
  output logic                ir_tdo,
  output logic                tdo_en,
  output logic                dr_capture,
  output logic                dr_shift,
  output logic                dr_update,
  output logic                ir_shift,
  output logic [IR_WIDTH-1:0] parallel_out
);
  typedef enum logic [3:0] {
    TLR      = 4'd0,
    RTI      = 4'd1,
    SEL_DR   = 4'd2,
    CAP_DR   = 4'd3,
    SHIFT_DR = 4'd4,
    EXIT1_DR = 4'd5,
    PAUSE_DR = 4'd6,
    EXIT2_DR = 4'd7,
    UPD_DR   = 4'd8,
    SEL_IR   = 4'd9,
    CAP_IR   = 4'd10,
    SHIFT_IR = 4'd11,
    EXIT1_IR = 4'd12,
    PAUSE_IR = 4'd13,
    EXIT2_IR = 4'd14,
    UPD_IR   = 4'd15
  } state_t;
  state_t              state_q, state_d;
  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  // next TAP state from the 1149.1 transition graph
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:      state_d = TMS ? TLR      : RTI;
      RTI:      state_d = TMS ? SEL_DR   : RTI;
      SEL_DR:   state_d = TMS ? SEL_IR   : CAP_DR;
      CAP_DR:   state_d = TMS ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: state_d = TMS ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: state_d = TMS ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_d = TMS ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: state_d = TMS ? UPD_DR   : SHIFT_DR;
      UPD_DR:   state_d = TMS ? SEL_DR   : RTI;
      SEL_IR:   state_d = TMS ? TLR      : CAP_IR;
      CAP_IR:   state_d = TMS ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: state_d = TMS ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: state_d = TMS ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_d = TMS ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: state_d = TMS ? UPD_IR   : SHIFT_IR;
      UPD_IR:   state_d = TMS ? SEL_DR   : RTI;
      default:  state_d = TLR;
    endcase
  end
  // IR shift path and committed instruction; TLR keeps forcing IDCODE
  always_comb begin
    ir_sr_d = state_q == CAP_IR   ? IR_CAPTURE :
              state_q == SHIFT_IR ? {TDI, ir_sr_q[IR_WIDTH-1:1]} : ir_sr_q;
    ir_d    = state_q == TLR      ? IDCODE_OP :
              state_q == UPD_IR   ? ir_sr_q : ir_q;
  end
  // state and registers; TRST overrides any shift, capture or update
  always_ff @(posedge TCK) begin
    if (TRST) begin
      state_q <= TLR;
      ir_sr_q <= IR_CAPTURE;
      ir_q    <= IDCODE_OP;
    end else begin
      state_q <= state_d;
      ir_sr_q <= ir_sr_d;
      ir_q    <= ir_d;
    end
  end
  assign tap_state    = state_q;
  assign ir_tdo       = ir_sr_q[0];
  assign tdo_en       = state_q == SHIFT_DR || state_q == SHIFT_IR;
  assign dr_capture   = state_q == CAP_DR;
  assign dr_shift     = state_q == SHIFT_DR;
  assign dr_update    = state_q == UPD_DR;
  assign ir_shift     = state_q == SHIFT_IR;
  assign parallel_out = ir_q;
endmodule
